sar_spi_frame_rx: RTL and testbench

//  Downstream capture stage for the oversampling SAR ADC serial output. Samples spi_sclk/spi_miso

---
 rtl/sar_rx_pkg.sv | 16 +
 rtl/sar_rx_fifo.sv | 66 ++++++
 rtl/sar_spi_frame_rx.sv | 152 +++++++++++++++
 tb/tb_sar_spi_frame_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_rx_pkg.sv
// Shared types and default sizes for the SAR ADC SPI frame receiver.
// Contents: FSM state enum and default parameter values.
package sar_rx_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int FIFO_DEPTH_DEF  = 4;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_CYC_DEF = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PUSH  = 2'd2
   } rx_state_e;

endpackage

// File: rtl/sar_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received ADC words.
// Ports: clk/reset, clr (flush), push/wdata, pop/rdata, level/full/empty.
module sar_rx_fifo
   import sar_rx_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             wdata,
   output logic [DATA_W-1:0]             rdata,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_q;
   logic [PTR_W-1:0]  rd_q;
   logic [LVL_W-1:0]  level_q;
   logic              do_push;
   logic              do_pop;

   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty = (level_q == '0);

   // A push into a full FIFO is accepted only when a pop frees the slot
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else if (clr) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_q] <= wdata;
   end

   // Forced to zero when empty so stale storage never shows on the bus
   assign rdata = empty ? '0 : mem_q[rd_q];
   assign level = level_q;

endmodule

// File: rtl/sar_spi_frame_rx.sv
// SAR ADC SPI capture: synchronises sclk/miso, deserialises MSB-first
// frames and streams them out via a FWFT FIFO (m_data/m_valid/m_ready).
// Ports: clk, reset, spi_sclk, spi_miso, clr, m_data, m_valid, m_ready,
// fifo_level, overflow (sticky drop), frame_err (sticky timeout).
module sar_spi_frame_rx
   import sar_rx_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          spi_sclk,
   input  logic                          spi_miso,
   input  logic                          clr,
   output logic [DATA_W-1:0]             m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] miso_sync_q;
   logic                   sclk_prev_q;
   logic [SYNC_STAGES:0]   primed_q;
   logic                   sclk_s;
   logic                   miso_s;
   logic                   sclk_rise;

   rx_state_e         state_q;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [TMR_W-1:0]  tmr_q;
   logic              overflow_q;
   logic              frame_err_q;

   logic fifo_push;
   logic fifo_pop;
   logic fifo_full;
   logic fifo_empty;
   logic push_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync_q <= '0;
         miso_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         primed_q    <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], spi_miso};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         primed_q    <= {primed_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign miso_s = miso_sync_q[SYNC_STAGES-1];

   // Edges are ignored until the cleared synchroniser has refilled, so a
   // sclk held high through reset does not look like a fresh rising edge
   assign sclk_rise = primed_q[SYNC_STAGES] & sclk_s & ~sclk_prev_q;

   assign fifo_pop  = m_valid & m_ready;
   assign fifo_push = (state_q == PUSH) & ~clr;
   assign push_ok   = ~fifo_full | fifo_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         tmr_q       <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else if (clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tmr_q       <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sclk_rise) begin
                  shift_q <= {shift_q[DATA_W-2:0], miso_s};
                  cnt_q   <= CNT_W'(1);
                  tmr_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shift_q <= {shift_q[DATA_W-2:0], miso_s};
                  cnt_q   <= cnt_q + 1'b1;
                  tmr_q   <= '0;
                  if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= PUSH;
               end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                  frame_err_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            PUSH: begin
               if (!push_ok) overflow_q <= 1'b1;
               // The FIFO takes shift_q this cycle; an edge here opens
               // the next frame without passing through IDLE
               if (sclk_rise) begin
                  shift_q <= {shift_q[DATA_W-2:0], miso_s};
                  cnt_q   <= CNT_W'(1);
                  tmr_q   <= '0;
                  state_q <= SHIFT;
               end else begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sar_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (shift_q),
      .rdata (m_data),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign m_valid   = ~fifo_empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sar_spi_frame_rx.sv
// Bench for sar_spi_frame_rx: frame table plus hand-built corner cases,
// output words checked against a queue of expected results.
module tb_sar_spi_frame_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_sclk;
   logic       spi_miso;
   logic       clr;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       frame_err;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   sar_spi_frame_rx dut (
      .clk        (clk),
      .reset      (reset),
      .spi_sclk   (spi_sclk),
      .spi_miso   (spi_miso),
      .clr        (clr),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #20 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         nbits;
      logic       exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         spi_sclk = 1'b0;
         spi_miso = w[i];
         cyc(4);
         spi_sclk = 1'b1;
         cyc(4);
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      exp_q.delete();
      cyc(1);
   endtask

   task automatic wait_empty(input string nm, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
      chk(nm, exp_q.size(), 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, m_valid, 0);
      chk({nm, "_data"}, m_data, 0);
      chk({nm, "_level"}, fifo_level, 0);
      chk({nm, "_ovf"}, overflow, 0);
      chk({nm, "_ferr"}, frame_err, 0);
   endtask

   // Scoreboard: every accepted word must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_spurious got=%0h exp=none", m_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (m_data !== e) begin
               n_err++;
               $display("FAIL pop_data got=%0h exp=%0h", m_data, e);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      tbl[0] = '{8'h8C, 8, 1'b0};
      tbl[1] = '{8'h00, 8, 1'b0};
      tbl[2] = '{8'hFF, 8, 1'b0};
      tbl[3] = '{8'h3C, 5, 1'b1};
      tbl[4] = '{8'hA5, 8, 1'b1};

      reset    = 1'b1;
      spi_sclk = 1'b0;
      spi_miso = 1'b0;
      clr      = 1'b0;
      m_ready  = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(25);
      chk_zero("idle_lo");

      spi_sclk = 1'b1;
      spi_miso = 1'b1;
      reset    = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(25);
      chk_zero("idle_hi");
      spi_sclk = 1'b0;
      cyc(5);

      m_ready = 1'b1;
      foreach (tbl[k]) begin
         send_bits(tbl[k].data, tbl[k].nbits);
         if (tbl[k].nbits == 8) exp_q.push_back(tbl[k].data);
         if (tbl[k].nbits < 8) cyc(100);
         cyc(6);
         chk("tbl_drain", exp_q.size(), 0);
         chk("tbl_level", fifo_level, 0);
         chk("tbl_ferr", frame_err, tbl[k].exp_err);
      end
      do_clr();
      chk("clr_ferr", frame_err, 0);

      m_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_bits(8'(k), 8);
         if (k <= 4) exp_q.push_back(8'(k));
      end
      cyc(6);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", m_data, 8'h01);
      m_ready = 1'b1;
      wait_empty("ovf_drain", 20);
      cyc(2);
      chk("ovf_level0", fifo_level, 0);
      chk("ovf_sticky", overflow, 1);
      do_clr();
      chk("ovf_clr", overflow, 0);

      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send_bits(8'h11 + 8'(k), 8);
         exp_q.push_back(8'h11 + 8'(k));
      end
      cyc(6);
      chk("full_level", fifo_level, 4);
      exp_q.push_back(8'h15);
      send_bits(8'h15, 7);
      spi_sclk = 1'b0;
      spi_miso = 1'b1;
      cyc(4);
      spi_sclk = 1'b1;
      cyc(3);
      m_ready = 1'b1;
      cyc(1);
      m_ready = 1'b0;
      cyc(6);
      chk("pp_level", fifo_level, 4);
      chk("pp_ovf", overflow, 0);
      chk("pp_head", m_data, 8'h12);
      m_ready = 1'b1;
      wait_empty("pp_drain", 20);

      m_ready = 1'b0;
      send_bits(8'hF0, 4);
      reset = 1'b1;
      exp_q.delete();
      cyc(2);
      chk_zero("rst_mid");
      reset = 1'b0;
      cyc(10);
      chk("rst_level", fifo_level, 0);
      for (int k = 0; k < 3; k++) begin
         send_bits(8'h21 + 8'(k), 8);
         exp_q.push_back(8'h21 + 8'(k));
      end
      cyc(6);
      chk("l3_level", fifo_level, 3);
      do_clr();
      chk_zero("clr3");
      m_ready = 1'b1;
      send_bits(8'h5A, 8);
      exp_q.push_back(8'h5A);
      cyc(4);
      wait_empty("5a_drain", 20);
      cyc(2);
      chk("5a_level", fifo_level, 0);
      chk("5a_ferr", frame_err, 0);
      chk("5a_ovf", overflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
